// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime with prescaler, mtimecmp and msip on a
// single-cycle-response bus, driving the timer and software interrupt lines.
module clint #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [13:0] W_MSIP    = 14'h0000;
  localparam logic [13:0] W_CMP_LO  = 14'h1000;
  localparam logic [13:0] W_CMP_HI  = 14'h1001;
  localparam logic [13:0] W_TIME_LO = 14'h2FFE;
  localparam logic [13:0] W_TIME_HI = 14'h2FFF;

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, timer_q, soft_q;
  logic        tick, wr, rd;
  logic [13:0] word;
  logic        unused_addr_bits;

  assign word             = addr[15:2];
  assign unused_addr_bits = ^addr[1:0];
  assign wr               = req & we;
  assign rd               = req & ~we;
  assign tick             = (presc_q == PRESC_MAX);

  always_comb begin
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;
    // A write to either mtime half suppresses that cycle's increment entirely.
    if (wr && word == W_TIME_LO)      mtime_d[31:0]  = wdata;
    else if (wr && word == W_TIME_HI) mtime_d[63:32] = wdata;
    else if (tick)                    mtime_d        = mtime_q + 64'd1;
    if (wr && word == W_CMP_LO) mtimecmp_d[31:0]  = wdata;
    if (wr && word == W_CMP_HI) mtimecmp_d[63:32] = wdata;
    if (wr && word == W_MSIP)   msip_d            = wdata[0];
    if (rd) begin
      case (word)
        W_MSIP:    rdata_d = {31'd0, msip_q};
        W_CMP_LO:  rdata_d = mtimecmp_q[31:0];
        W_CMP_HI:  rdata_d = mtimecmp_q[63:32];
        W_TIME_LO: rdata_d = mtime_q[31:0];
        W_TIME_HI: rdata_d = mtime_q[63:32];
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= {64{1'b1}};
      msip_q     <= 1'b0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      timer_q    <= 1'b0;
      soft_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      ready_q    <= req;
      timer_q    <= (mtime_q >= mtimecmp_q);
      soft_q     <= msip_q;
    end
  end

  assign rdata              = rdata_q;
  assign ready              = ready_q;
  assign timer_interrupt    = timer_q;
  assign software_interrupt = soft_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (PRESCALE 1 and 4) share one bus and are
// compared each cycle against a behavioural register-map model.
module tb_clint;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] d_rdata [2];
  logic        d_ready [2];
  logic        d_ti [2];
  logic        d_si [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  clint #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(d_rdata[0]), .ready(d_ready[0]),
    .timer_interrupt(d_ti[0]), .software_interrupt(d_si[0]));

  clint #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(d_rdata[1]), .ready(d_ready[1]),
    .timer_interrupt(d_ti[1]), .software_interrupt(d_si[1]));

  // Reference model: architectural state plus cycles elapsed since reset.
  int unsigned     P [2] = '{1, 4};
  logic [63:0]     m_time [2];
  logic [63:0]     m_cmp [2];
  logic            m_msip [2];
  longint unsigned m_cyc [2];
  logic [31:0]     m_rd [2];
  logic            m_rdy [2];
  logic            m_ti [2];
  logic            m_si [2];

  function automatic logic [31:0] m_read(int i, logic [15:0] a);
    case (a & 16'hFFFC)
      16'h0000: return {31'd0, m_msip[i]};
      16'h4000: return m_cmp[i][31:0];
      16'h4004: return m_cmp[i][63:32];
      16'hBFF8: return m_time[i][31:0];
      16'hBFFC: return m_time[i][63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_time[i] = 64'd0; m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF; m_msip[i] = 1'b0;
        m_cyc[i] = 0; m_rd[i] = 32'd0; m_rdy[i] = 1'b0; m_ti[i] = 1'b0; m_si[i] = 1'b0;
      end else begin
        logic        tick;
        logic [15:0] a;
        a    = addr & 16'hFFFC;
        tick = (m_cyc[i] % P[i]) == P[i] - 1;
        m_ti[i]  = m_time[i] >= m_cmp[i];
        m_si[i]  = m_msip[i];
        m_rdy[i] = req;
        if (req && !we) m_rd[i] = m_read(i, addr);
        if (req && we && a == 16'hBFF8)      m_time[i] = {m_time[i][63:32], wdata};
        else if (req && we && a == 16'hBFFC) m_time[i] = {wdata, m_time[i][31:0]};
        else if (tick)                       m_time[i] = m_time[i] + 64'd1;
        if (req && we && a == 16'h4000) m_cmp[i][31:0]  = wdata;
        if (req && we && a == 16'h4004) m_cmp[i][63:32] = wdata;
        if (req && we && a == 16'h0000) m_msip[i] = wdata[0];
        m_cyc[i]++;
      end
    end
  endtask

  // One bus cycle: drive, clock, advance the model, settle before sampling.
  task automatic cycle(logic r, logic w, logic [15:0] a, logic [31:0] d);
    req = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_step();
    #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0, 16'hBFF8, 32'd0);
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if ({d_ready[i], d_ti[i], d_si[i], d_rdata[i]} !== 35'd0)
          $display("FAIL reset_outputs[%0d] got=%h exp=0", i,
                   {d_ready[i], d_ti[i], d_si[i], d_rdata[i]});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_idle_count();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 16'd0, 32'd0);
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if ({d_ti[i], d_si[i]} !== 2'b00)
          $display("FAIL idle_irq[%0d] got=%b exp=00", i, {d_ti[i], d_si[i]});
        else pass_cnt++;
      end
    end
    cycle(1'b1, 1'b0, 16'hBFF8, 32'd0);
    total_cnt++;
    if (d_rdata[0] !== 32'd10) $display("FAIL idle_mtime_p1 got=%0d exp=10", d_rdata[0]);
    else pass_cnt++;
    total_cnt++;
    if (d_rdata[1] !== 32'd2) $display("FAIL idle_mtime_p4 got=%0d exp=2", d_rdata[1]);
    else pass_cnt++;
  endtask

  task automatic test_timer();
    cycle(1'b1, 1'b1, 16'h4004, 32'd0);
    cycle(1'b1, 1'b1, 16'h4000, 32'd20);
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b0, 16'd0, 32'd0);
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if (d_ti[i] !== m_ti[i])
          $display("FAIL timer_track[%0d] got=%b exp=%b", i, d_ti[i], m_ti[i]);
        else pass_cnt++;
      end
    end
    cycle(1'b1, 1'b1, 16'h4000, 32'd1000);
    total_cnt++;
    if (d_ti[0] !== 1'b1) $display("FAIL timer_hold got=%b exp=1", d_ti[0]);
    else pass_cnt++;
    cycle(1'b0, 1'b0, 16'd0, 32'd0);
    total_cnt++;
    if (d_ti[0] !== 1'b0) $display("FAIL timer_fall got=%b exp=0", d_ti[0]);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    cycle(1'b1, 1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 16'hBFFC, 32'd0);
    cycle(1'b0, 1'b0, 16'd0, 32'd0);
    cycle(1'b1, 1'b0, 16'hBFFC, 32'd0);
    total_cnt++;
    if (d_rdata[0] !== 32'd1) $display("FAIL carry_hi got=%h exp=1", d_rdata[0]);
    else pass_cnt++;
    cycle(1'b1, 1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 16'hBFFC, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 16'hBFF8, 32'd0);
    total_cnt++;
    if (d_rdata[0] !== 32'hFFFF_FFFF) $display("FAIL wrap_pre got=%h exp=ffffffff", d_rdata[0]);
    else pass_cnt++;
    cycle(1'b1, 1'b0, 16'hBFFC, 32'd0);
    total_cnt++;
    if (d_rdata[0] !== 32'd0) $display("FAIL wrap_hi got=%h exp=0", d_rdata[0]);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (d_rdata[i] !== m_rd[i]) $display("FAIL carry_model[%0d] got=%h exp=%h", i, d_rdata[i], m_rd[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_msip();
    cycle(1'b1, 1'b1, 16'h0000, 32'hFFFF_FFFF);
    total_cnt++;
    if (d_si[0] !== 1'b0) $display("FAIL msip_early got=%b exp=0", d_si[0]);
    else pass_cnt++;
    cycle(1'b1, 1'b0, 16'h0000, 32'd0);
    total_cnt++;
    if (d_si[0] !== 1'b1) $display("FAIL msip_rise got=%b exp=1", d_si[0]);
    else pass_cnt++;
    total_cnt++;
    if (d_rdata[0] !== 32'd1) $display("FAIL msip_read got=%h exp=1", d_rdata[0]);
    else pass_cnt++;
    cycle(1'b1, 1'b1, 16'h0000, 32'd0);
    cycle(1'b0, 1'b0, 16'd0, 32'd0);
    total_cnt++;
    if (d_si[1] !== 1'b0) $display("FAIL msip_fall got=%b exp=0", d_si[1]);
    else pass_cnt++;
  endtask

  task automatic test_prescale();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 16'd0, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 1'b0, 16'hBFF8, 32'd0);
      total_cnt++;
      if (d_rdata[1] !== m_rd[1]) $display("FAIL presc_read got=%h exp=%h", d_rdata[1], m_rd[1]);
      else pass_cnt++;
    end
    for (int c = 0; c < 4 && (m_cyc[1] % 4) != 3; c++) cycle(1'b0, 1'b0, 16'd0, 32'd0);
    cycle(1'b1, 1'b1, 16'hBFF8, 32'h55);
    cycle(1'b1, 1'b0, 16'hBFF8, 32'd0);
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (d_rdata[i] !== 32'h55) $display("FAIL tick_write[%0d] got=%h exp=55", i, d_rdata[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 16'd0, 32'd0);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 16'h1234, 32'd0);
    cycle(1'b1, 1'b0, 16'hBFFC, 32'd0);
    cycle(1'b1, 1'b1, 16'h0008, 32'hDEAD_BEEF);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 16'h4000, 32'd0);
    total_cnt++;
    if (d_ready[0] !== 1'b0) $display("FAIL reset_drops_ready got=%b exp=0", d_ready[0]);
    else pass_cnt++;
    reset = 1'b0;
    cycle(1'b1, 1'b0, 16'h4004, 32'd0);
    total_cnt++;
    if (d_rdata[0] !== 32'hFFFF_FFFF) $display("FAIL cmp_reset got=%h exp=ffffffff", d_rdata[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] pool [7] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0008, 16'h1234};
    for (int c = 0; c < 400; c++) begin
      logic [15:0] a;
      logic [31:0] d;
      a = ($urandom_range(0, 7) == 7) ? 16'($urandom) : (pool[$urandom_range(0, 6)] | 16'($urandom_range(0, 3)));
      d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 200);
      reset = ($urandom_range(0, 63) == 0);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if ({d_ready[i], d_ti[i], d_si[i], d_rdata[i]} !== {m_rdy[i], m_ti[i], m_si[i], m_rd[i]})
          $display("FAIL random[%0d] cyc=%0d got=%h exp=%h", i, c,
                   {d_ready[i], d_ti[i], d_si[i], d_rdata[i]}, {m_rdy[i], m_ti[i], m_si[i], m_rd[i]});
        else pass_cnt++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_count();
    test_timer();
    test_carry();
    test_msip();
    test_prescale();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
